// File: rtl/vcve2_pkg.sv
// vcve2 shared types for the cluster sleep controller.
// Hart sleep FSM encoding and hold counter width.
package vcve2_pkg;

  localparam int unsigned SleepHoldW = 8;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    RUN   = 2'b01,
    HOLD  = 2'b10,
    SLEEP = 2'b11
  } sleep_state_e;

endpackage

// File: rtl/vcve2_sleep_ctrl_if.sv
// vcve2 sleep controller per-hart bundle.
// master = cluster side, slave = sleep controller.
interface vcve2_sleep_ctrl_if #(
  parameter int unsigned NumHarts  = 2,
  parameter int unsigned SleepCntW = 16
);

  logic [NumHarts-1:0]           fetch_req;
  logic [NumHarts-1:0]           core_busy;
  logic [NumHarts-1:0]           irq_pending;
  logic [NumHarts-1:0]           irq_nm;
  logic [NumHarts-1:0]           debug_req;
  logic [NumHarts-1:0]           fetch_enable;
  logic [NumHarts-1:0]           clock_en;
  logic [NumHarts-1:0]           core_sleep;
  logic                          all_sleep;
  logic [NumHarts*SleepCntW-1:0] sleep_cnt;

  modport master (
    output fetch_req, core_busy, irq_pending, irq_nm, debug_req,
    input  fetch_enable, clock_en, core_sleep, all_sleep, sleep_cnt
  );

  modport slave (
    input  fetch_req, core_busy, irq_pending, irq_nm, debug_req,
    output fetch_enable, clock_en, core_sleep, all_sleep, sleep_cnt
  );

endinterface

// File: rtl/vcve2_sleep_ch.sv
// vcve2 single-hart sleep channel: fetch latch, idle/sleep FSM,
// hold counter and sleep-entry counter.
module vcve2_sleep_ch
  import vcve2_pkg::*;
#(
  parameter int unsigned IdleHoldCycles = 4,
  parameter int unsigned SleepCntW      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 test_en_i,
  input  logic                 fetch_enable_i,
  input  logic                 core_busy_i,
  input  logic                 irq_pending_i,
  input  logic                 irq_nm_i,
  input  logic                 debug_req_i,
  output logic                 fetch_enable_o,
  output logic                 clock_en_o,
  output logic                 core_sleep_o,
  output logic [SleepCntW-1:0] sleep_cnt_o
);

  localparam logic [SleepHoldW-1:0] HoldLoad =
    (IdleHoldCycles == 0) ? '0 : SleepHoldW'(IdleHoldCycles - 1);

  sleep_state_e          state_q, state_d;
  logic [SleepHoldW-1:0] hold_q, hold_d;
  logic [SleepCntW-1:0]  cnt_q, cnt_d;
  logic                  wake;
  logic                  enter;

  assign wake = core_busy_i | irq_pending_i |
                irq_nm_i | debug_req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OFF;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    enter   = 1'b0;
    unique case (state_q)
      OFF: begin
        if (fetch_enable_i) state_d = RUN;
      end
      RUN: begin
        if (!wake) begin
          if (IdleHoldCycles == 0) begin
            state_d = SLEEP;
            enter   = 1'b1;
          end else begin
            state_d = HOLD;
            hold_d  = HoldLoad;
          end
        end
      end
      HOLD: begin
        // wake beats an expiring hold counter
        if (wake) begin
          state_d = RUN;
        end else if (hold_q == '0) begin
          state_d = SLEEP;
          enter   = 1'b1;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      SLEEP: begin
        if (wake) state_d = RUN;
      end
    endcase
    cnt_d = cnt_q + SleepCntW'(enter);
  end

  // only reset returns to OFF, so this is the sticky fetch latch
  assign fetch_enable_o = (state_q != OFF);
  assign clock_en_o     = test_en_i |
                          (state_q == RUN) |
                          (state_q == HOLD) |
                          ((state_q == SLEEP) & wake);
  assign core_sleep_o   = (state_q == SLEEP) & !wake;
  assign sleep_cnt_o    = cnt_q;

endmodule

// File: rtl/vcve2_sleep_ctrl.sv
// vcve2 multi-hart clock-enable and sleep controller.
// One independent channel per hart plus the all-sleep reduction.
module vcve2_sleep_ctrl
  import vcve2_pkg::*;
#(
  parameter int unsigned NumHarts       = 2,
  parameter int unsigned IdleHoldCycles = 4,
  parameter int unsigned SleepCntW      = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               test_en_i,
  vcve2_sleep_ctrl_if.slave  bus
);

  for (genvar h = 0; h < NumHarts; h++) begin : g_hart
    vcve2_sleep_ch #(
      .IdleHoldCycles (IdleHoldCycles),
      .SleepCntW      (SleepCntW)
    ) u_ch (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .test_en_i      (test_en_i),
      .fetch_enable_i (bus.fetch_req[h]),
      .core_busy_i    (bus.core_busy[h]),
      .irq_pending_i  (bus.irq_pending[h]),
      .irq_nm_i       (bus.irq_nm[h]),
      .debug_req_i    (bus.debug_req[h]),
      .fetch_enable_o (bus.fetch_enable[h]),
      .clock_en_o     (bus.clock_en[h]),
      .core_sleep_o   (bus.core_sleep[h]),
      .sleep_cnt_o    (bus.sleep_cnt[h*SleepCntW +: SleepCntW])
    );
  end

  assign bus.all_sleep = &bus.core_sleep;

endmodule
